// File: rtl/out_fifo_stage.sv
// rtl/out_fifo_stage.sv - fall-through FIFO stage between the channel arbiter and the output consumer
// Optional per-channel pop statistics are enabled with OUT_FIFO_STATS_EN.
module out_fifo_stage #(
  parameter int  DATA_W = 32,
  parameter int  CH_NUM = 8,
  parameter int  DEPTH  = 8,
  localparam int ID_W   = $clog2(CH_NUM),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ID_W-1:0]   in_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
`ifdef OUT_FIFO_STATS_EN
  ,
  input  logic [ID_W-1:0]   stat_sel,
  input  logic              stat_clr,
  output logic [15:0]       stat_cnt
`endif
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ID_W-1:0]   r_mem_id   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_push;
  logic w_pop;

  // Handshake flags come only from registered occupancy, so out_ready never reaches in_ready.
  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign out_data = empty ? '0 : r_mem_data[r_rd_ptr];
  assign out_id   = empty ? '0 : r_mem_id[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= in_data;
      r_mem_id[r_wr_ptr]   <= in_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef OUT_FIFO_STATS_EN
  logic [15:0] r_stat_cnt [CH_NUM];

  // Clear takes priority over a same-cycle pop; counters stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH_NUM; i++) r_stat_cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < CH_NUM; i++) r_stat_cnt[i] <= '0;
    end else if (w_pop && (int'(out_id) < CH_NUM)) begin
      if (r_stat_cnt[out_id] != 16'hFFFF) r_stat_cnt[out_id] <= r_stat_cnt[out_id] + 16'd1;
    end
  end

  assign stat_cnt = (int'(stat_sel) < CH_NUM) ? r_stat_cnt[stat_sel] : 16'h0000;
`endif

endmodule

// File: tb/tb_out_fifo_stage.sv
// tb/tb_out_fifo_stage.sv - directed self-checking bench for out_fifo_stage
module tb_out_fifo_stage;

  localparam int DATA_W = 32;
  localparam int ID_W   = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ID_W-1:0]   in_id;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ID_W-1:0]   out_id;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
`ifdef OUT_FIFO_STATS_EN
  logic [ID_W-1:0]   stat_sel;
  logic              stat_clr;
  logic [15:0]       stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  out_fifo_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_id     (in_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef OUT_FIFO_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] sb_data [$];
  logic [ID_W-1:0]   sb_id   [$];
  logic              m_push;
  logic              m_pop;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_id     = '0;
    out_ready = 1'b0;
`ifdef OUT_FIFO_STATS_EN
    stat_sel  = '0;
    stat_clr  = 1'b0;
`endif

    // 1: reset
    #25;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 2: fill to full with consumer stalled, then drain in order
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      in_id    = 3'(i);
      tick();
      if (i == 0) begin
        chk("fall_through_valid", out_valid, 1);
        chk("fall_through_data", out_data, 32'h100);
        chk("fall_through_count", count, 1);
      end
    end
    in_valid = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 8);
    tick();
    chk("stall_data", out_data, 32'h100);
    chk("stall_id", out_id, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 32'h100 + 32'(i));
      chk("drain_id", out_id, 64'(i));
      tick();
    end
    chk("drain_empty", empty, 1);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_count", count, 0);

    // 3: streaming from empty, one word per cycle, occupancy stays 1
    in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_data = 32'h200 + 32'(k);
      in_id   = 3'(k);
      tick();
      chk("stream_data", out_data, 32'h200 + 32'(k));
      chk("stream_id", out_id, 64'(k % 8));
      chk("stream_count", count, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_empty", empty, 1);
    out_ready = 1'b0;

    // 4: full FIFO, single-cycle pop; push is refused that cycle and taken next
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h300 + 32'(i);
      in_id    = 3'(i);
      tick();
    end
    in_data   = 32'h3AA;
    in_id     = 3'd5;
    out_ready = 1'b1;
    chk("fullpop_in_ready_before", in_ready, 0);
    tick();
    out_ready = 1'b0;
    chk("fullpop_count", count, 7);
    chk("fullpop_in_ready_after", in_ready, 1);
    chk("fullpop_head", out_data, 32'h301);
    tick();
    in_valid = 1'b0;
    chk("fullpop_refill_count", count, 8);
    chk("fullpop_refill_full", full, 1);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("fullpop_drain_data", out_data, 32'h300 + 32'(i));
      tick();
    end
    chk("fullpop_tail_data", out_data, 32'h3AA);
    chk("fullpop_tail_id", out_id, 5);
    tick();
    chk("fullpop_tail_empty", empty, 1);
    out_ready = 1'b0;

    // 5: random traffic against a queue scoreboard
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0) ? (c % 200 < 100) : 1'b0;
      in_data   = $urandom;
      in_id     = 3'($urandom_range(0, 7));
      #1;
      chk("rand_out_valid", out_valid, (sb_data.size() > 0));
      if (sb_data.size() > 0) begin
        chk("rand_data", out_data, sb_data[0]);
        chk("rand_id", out_id, sb_id[0]);
      end
      chk("rand_in_ready", in_ready, (sb_data.size() < 8));
      m_push = in_valid && (sb_data.size() < 8);
      m_pop  = out_ready && (sb_data.size() > 0);
      tick();
      if (m_pop) begin
        void'(sb_data.pop_front());
        void'(sb_id.pop_front());
      end
      if (m_push) begin
        sb_data.push_back(in_data);
        sb_id.push_back(in_id);
      end
      chk("rand_count", count, 64'(sb_data.size()));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset while words are buffered
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_count", count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_data.delete();
    sb_id.delete();

`ifdef OUT_FIFO_STATS_EN
    // 6: per-channel pop counters
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      in_id    = (i < 10) ? 3'd3 : 3'd7;
      tick();
    end
    in_valid = 1'b0;
    tick();
    stat_sel = 3'd3;
    #1;
    chk("stat_ch3", stat_cnt, 10);
    stat_sel = 3'd7;
    #1;
    chk("stat_ch7", stat_cnt, 5);
    stat_sel = 3'd0;
    #1;
    chk("stat_ch0", stat_cnt, 0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    stat_sel = 3'd3;
    #1;
    chk("stat_clr_ch3", stat_cnt, 0);
    stat_sel = 3'd7;
    #1;
    chk("stat_clr_ch7", stat_cnt, 0);
    out_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
